// File: rtl/vlog_push_crc_if.sv
// Job/result bundle between a producer (master) and the CRC-8 push engine (slave).
// The master supplies the two payload words and the result-ready signal;
// the engine returns the per-word consumption pulses and the CRC result.
interface vlog_push_crc_if;
    logic        new_data;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic        crc_ready;
    logic        push_a_done;
    logic        push_b_done;
    logic        crc_valid;
    logic [7:0]  crc_out;
    logic        crc_done;
    logic        busy;

    modport master (
        output new_data,
        output data_a,
        output data_b,
        output crc_ready,
        input  push_a_done,
        input  push_b_done,
        input  crc_valid,
        input  crc_out,
        input  crc_done,
        input  busy
    );

    modport slave (
        input  new_data,
        input  data_a,
        input  data_b,
        input  crc_ready,
        output push_a_done,
        output push_b_done,
        output crc_valid,
        output crc_out,
        output crc_done,
        output busy
    );
endinterface

// File: rtl/vlog_push_crc.sv
// Four-byte CRC-8 push engine: captures two 16-bit words, folds one byte per
// cycle into a CRC-8 (MSB-first, non-reflected, no final XOR), then presents
// the result with a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for new_data; only state that accepts a job
// PUSH_A | folding data_a[15:8] then data_a[7:0]
// PUSH_B | folding data_b[15:8] then data_b[7:0]
// CRC    | crc_valid high, holding crc_out until crc_ready
module vlog_push_crc #(
    parameter logic [7:0] POLY = 8'h07,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    vlog_push_crc_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PUSH_A = 2'd1,
        PUSH_B = 2'd2,
        CRC    = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] word_a;
    logic [15:0] word_b;
    logic [1:0]  byte_cnt;
    logic [7:0]  crc_reg;
    logic [7:0]  cur_byte;
    logic [7:0]  crc_next;
    logic        push_a_done_r;
    logic        push_b_done_r;
    logic        crc_valid_r;
    logic [7:0]  crc_out_r;

    // Eight serial shift steps of the CRC-8 LFSR for one byte, MSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] din);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ din[i];
            c  = {c[6:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Byte selection follows the byte counter: a-high, a-low, b-high, b-low.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_cnt)
            2'd0:    cur_byte = word_a[15:8];
            2'd1:    cur_byte = word_a[7:0];
            2'd2:    cur_byte = word_b[15:8];
            default: cur_byte = word_b[7:0];
        endcase
        crc_next = crc8_byte(crc_reg, cur_byte);
    end

    // Main sequencer: job capture, byte folding, registered pulses and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            word_a        <= 16'h0000;
            word_b        <= 16'h0000;
            byte_cnt      <= 2'd0;
            crc_reg       <= 8'h00;
            push_a_done_r <= 1'b0;
            push_b_done_r <= 1'b0;
            crc_valid_r   <= 1'b0;
            crc_out_r     <= 8'h00;
        end else begin
            push_a_done_r <= 1'b0;
            push_b_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.new_data) begin
                        word_a   <= bus.data_a;
                        word_b   <= bus.data_b;
                        crc_reg  <= INIT;
                        byte_cnt <= 2'd0;
                        state    <= PUSH_A;
                    end
                end
                PUSH_A: begin
                    crc_reg  <= crc_next;
                    byte_cnt <= byte_cnt + 2'd1;
                    // The pulse is registered here so it is high during the second byte cycle.
                    if (!byte_cnt[0]) begin
                        push_a_done_r <= 1'b1;
                    end else begin
                        state <= PUSH_B;
                    end
                end
                PUSH_B: begin
                    crc_reg  <= crc_next;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (!byte_cnt[0]) begin
                        push_b_done_r <= 1'b1;
                    end else begin
                        // crc_out is a separate register so it survives after the handshake.
                        crc_out_r   <= crc_next;
                        crc_valid_r <= 1'b1;
                        state       <= CRC;
                    end
                end
                CRC: begin
                    if (bus.crc_ready) begin
                        crc_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    crc_valid_r <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // crc_done must coincide with the accepting cycle, so it is decoded from the held valid.
    always_comb begin
        bus.push_a_done = push_a_done_r;
        bus.push_b_done = push_b_done_r;
        bus.crc_valid   = crc_valid_r;
        bus.crc_out     = crc_out_r;
        bus.crc_done    = crc_valid_r & bus.crc_ready;
        bus.busy        = (state != IDLE);
    end

endmodule

// File: tb/tb_vlog_push_crc.sv
// Scoreboard bench for vlog_push_crc: expected CRCs are queued when a job is
// driven and checked when crc_done is seen; job timing is checked per cycle.
module tb_vlog_push_crc;

    logic clk;
    logic rst;

    vlog_push_crc_if bus ();

    vlog_push_crc #(.POLY(8'h07), .INIT(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp;
    int         n_err;
    int         done_seen;
    int         jobs_done;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference CRC-8 over the 32-bit message, bit-serial, MSB first.
    function automatic logic [7:0] crc_model(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] msg;
        logic [7:0]  c;
        logic        fb;
        msg = {a, b};
        c   = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ msg[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Result side of the scoreboard plus pulse exclusivity.
    always @(negedge clk) begin
        if (!rst) begin
            if ((32'(bus.push_a_done) + 32'(bus.push_b_done) + 32'(bus.crc_done)) > 1)
                chk("pulse_overlap", {29'd0, bus.push_a_done, bus.push_b_done, bus.crc_done}, 32'd0);
            if (bus.crc_done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("crc_out", {24'd0, bus.crc_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int stall, input bit poke);
        logic [7:0] exp;
        logic [2:0] pat [1:5];
        pat[1] = 3'b000; pat[2] = 3'b100; pat[3] = 3'b000; pat[4] = 3'b010; pat[5] = 3'b001;
        exp = crc_model(a, b);
        @(posedge clk); #1;
        bus.new_data  = 1'b1;
        bus.data_a    = a;
        bus.data_b    = b;
        bus.crc_ready = 1'b0;
        exp_q.push_back(exp);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus.new_data = poke;
            if (poke) begin
                bus.data_a = ~a;
                bus.data_b = a ^ b ^ 16'h5a5a;
            end
            if (k == 5) bus.crc_ready = (stall == 0);
            @(negedge clk);
            chk($sformatf("seq_k%0d", k), {29'd0, bus.push_a_done, bus.push_b_done, bus.crc_valid}, {29'd0, pat[k]});
            chk("busy_job", {31'd0, bus.busy}, 32'd1);
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            bus.new_data = poke;
            @(negedge clk);
            chk("stall_valid", {31'd0, bus.crc_valid}, 32'd1);
            chk("stall_crc", {24'd0, bus.crc_out}, {24'd0, exp});
            chk("stall_nodone", {31'd0, bus.crc_done}, 32'd0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            bus.crc_ready = 1'b1;
            bus.new_data  = poke;
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, bus.crc_done}, 32'd1);
        jobs_done++;
        @(posedge clk); #1;
        bus.new_data  = 1'b0;
        bus.crc_ready = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("crc_retained", {24'd0, bus.crc_out}, {24'd0, exp});
        @(negedge clk);
        chk("no_phantom_job", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic reset_mid_job(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        bus.new_data  = 1'b1;
        bus.data_a    = a;
        bus.data_b    = b;
        bus.crc_ready = 1'b1;
        exp_q.push_back(crc_model(a, b));
        @(posedge clk); #1;
        bus.new_data = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_state_pushb", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pushb", {31'd0, bus.push_b_done}, 32'd0);
        chk("rst_valid", {31'd0, bus.crc_valid}, 32'd0);
        chk("rst_crc_out", {24'd0, bus.crc_out}, 32'd0);
        chk("rst_done", {31'd0, bus.crc_done}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_pushb", {31'd0, bus.push_b_done}, 32'd0);
            chk("post_rst_valid", {31'd0, bus.crc_valid}, 32'd0);
        end
        bus.crc_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_cmp = 0; n_err = 0; done_seen = 0; jobs_done = 0;
        rst = 1'b1;
        bus.new_data = 1'b0; bus.data_a = 16'h0; bus.data_b = 16'h0; bus.crc_ready = 1'b0;
        #1;
        chk("rst0_outputs", {24'd0, bus.push_a_done, bus.push_b_done, bus.crc_valid, bus.crc_done, bus.busy, 3'd0}, 32'd0);
        chk("rst0_crc_out", {24'd0, bus.crc_out}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_rst", {31'd0, bus.busy}, 32'd0);
        end

        run_job(16'h0000, 16'h0001, 0, 1'b0);
        chk("crc_single_bit", {24'd0, bus.crc_out}, 32'h07);
        run_job(16'h0000, 16'h0100, 0, 1'b0);
        chk("crc_shifted_byte", {24'd0, bus.crc_out}, 32'h15);
        run_job(16'h0000, 16'h0000, 0, 1'b0);
        chk("crc_all_zero", {24'd0, bus.crc_out}, 32'h00);
        run_job(16'hA5C3, 16'h1234, 10, 1'b0);
        run_job(16'hBEEF, 16'hCAFE, 2, 1'b1);
        run_job(16'h8001, 16'hFFFF, 0, 1'b1);
        reset_mid_job(16'h1357, 16'h9BDF);
        run_job(16'h1357, 16'h9BDF, 0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_job(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("done_count", done_seen, jobs_done);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vlog_push_crc.md
VLOG_PUSH_CRC -- requirements
Module: vlog_push_crc

Interface
REQ-001 SHALL have parameter POLY, default 8'h07, CRC-8 generator polynomial (implicit x^8).
REQ-002 SHALL have parameter INIT, default 8'h00, CRC register value loaded on each accepted job.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high; one clock domain only.
REQ-005 SHALL have port new_data  input  1  job request strobe, sampled only in IDLE.
REQ-006 SHALL have port data_a  input  16  first payload word, captured with new_data.
REQ-007 SHALL have port data_b  input  16  second payload word, captured with new_data.
REQ-008 SHALL have port crc_ready  input  1  downstream accepts crc_out when high with crc_valid.
REQ-009 SHALL have port push_a_done  output  1  one-cycle pulse: both bytes of data_a consumed.
REQ-010 SHALL have port push_b_done  output  1  one-cycle pulse: both bytes of data_b consumed.
REQ-011 SHALL have port crc_valid  output  1  crc_out valid, held until handshake.
REQ-012 SHALL have port crc_out  output  8  CRC-8 result of the 4-byte job.
REQ-013 SHALL have port crc_done  output  1  one-cycle pulse on the crc_valid & crc_ready cycle.
REQ-014 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement states IDLE, PUSH_A, PUSH_B, CRC, encoded in 2 bits, with an illegal or unreachable encoding recovering to IDLE.
REQ-016 In IDLE, new_data=1 SHALL capture data_a and data_b into internal registers, load the CRC register with INIT, clear the byte counter, and move to PUSH_A.
REQ-017 The input new_data SHALL be ignored in every state except IDLE; the captured words SHALL NOT change until the next accepted job.
REQ-018 The module SHALL process one byte per cycle, MSB-first, non-reflected, no final XOR, in the order data_a[15:8], data_a[7:0], data_b[15:8], data_b[7:0].
REQ-019 Per-byte update SHALL equal eight serial shift steps: each step XORs the CRC MSB with the data bit, shifts left, and XORs POLY if the result bit is 1; all arithmetic is 8-bit, discarding bit 8.
REQ-020 PUSH_A SHALL last exactly 2 cycles; push_a_done SHALL be 1 in the second cycle; the state SHALL then move to PUSH_B.
REQ-021 PUSH_B SHALL last exactly 2 cycles; push_b_done SHALL be 1 in the second cycle; the state SHALL then move to CRC.
REQ-022 In CRC, crc_valid SHALL be 1, and crc_out SHALL hold the final CRC, stable until handshake.
REQ-023 In CRC, crc_ready=1 SHALL assert crc_done for that cycle and move to IDLE; crc_ready=0 SHALL keep the state at CRC indefinitely.
REQ-024 Latency SHALL be fixed: new_data accepted in cycle N gives crc_valid=1 from cycle N+5.
REQ-025 A new_data pulse in the handshake cycle SHALL be ignored; the earliest new job is accepted in the cycle after crc_done.
REQ-026 Outside their defined cycles, push_a_done, push_b_done, and crc_done SHALL be 0 and SHALL never be asserted together.
REQ-027 crc_out SHALL retain its last value after the handshake until the next job completes.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force state=IDLE, crc_valid=0, push_a_done=0, push_b_done=0, crc_done=0, busy=0, crc_out=8'h00, and clear the captured words, counter, and CRC register to 0.
REQ-029 rst asserted mid-job, in any state, SHALL abandon the job; no done pulse SHALL follow after release.
REQ-030 After rst deassertion, the first rising edge SHALL be able to accept new_data.

Verification
REQ-031 Reset check: with rst=1 -> all outputs 0 and busy=0; after release, new_data held at 0 -> state remains IDLE.
REQ-032 Single-bit job: data_a=16'h0000, data_b=16'h0001, crc_ready=1 -> push_a_done in N+2, push_b_done in N+4, crc_valid and crc_done in N+5, crc_out=8'h07.
REQ-033 Shifted-byte job: data_a=16'h0000, data_b=16'h0100 -> crc_out=8'h15; all-zero job -> crc_out=8'h00.
REQ-034 Backpressure: crc_ready=0 for 10 cycles in CRC -> crc_valid stays 1 and crc_out stays stable; then crc_ready=1 -> one crc_done pulse, then IDLE.
REQ-035 Busy rejection: new_data pulsed in PUSH_A, PUSH_B, CRC, and the handshake cycle -> no extra job runs, and the captured data is unchanged.
REQ-036 Reset mid-job: rst asserted in PUSH_B -> outputs clear immediately; no push_b_done or crc_done follows; the next job produces the correct CRC.
